// File: rtl/mina_mem_sys.sv
// Memory-side responder for the MINA core: shared word RAM for IMEM/DMEM plus an MMIO window
// (cycle counter, console TX FIFO, sticky halt). Reads are combinational (0 cycles); writes land at the edge.
// Console drain is valid/ready: con_data is held until con_ready pops it; pushes into a full FIFO are dropped (OVF).
module mina_mem_sys #(
    parameter int          MEM_WORDS  = 16384,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
    parameter              INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wrdata,
    input  logic [3:0]  dmem_wrstb,
    output logic [31:0] dmem_rddata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halt
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    // MMIO register offsets, addressed by byte-address bits [3:2]
    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_CON    = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_HALT   = 2'd3;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] ram [MEM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Address decode (byte offset bits [1:0] are ignored on both ports)
    // ------------------------------------------------------------------
    function automatic logic in_ram(input logic [31:0] a);
        // every bit above the RAM's byte range must be zero
        return (a >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic in_mmio(input logic [31:0] a);
        return a[31:4] == MMIO_BASE[31:4];
    endfunction

    logic          i_ram;
    logic          d_ram;
    logic          d_mmio;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic [1:0]    d_off;

    assign i_ram  = in_ram(imem_addr);
    assign d_ram  = in_ram(dmem_addr);
    assign d_mmio = in_mmio(dmem_addr);
    assign i_idx  = imem_addr[AW+1:2];
    assign d_idx  = dmem_addr[AW+1:2];
    assign d_off  = dmem_addr[3:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[1:0], dmem_addr[1:0]};

    // ------------------------------------------------------------------
    // MMIO write decode: every MMIO side effect is keyed off byte lane 0
    // ------------------------------------------------------------------
    logic mmio_wr;
    logic push_req;
    logic ovf_clr;
    logic halt_set;

    assign mmio_wr  = d_mmio && dmem_wrstb[0];
    assign push_req = mmio_wr && (d_off == OFF_CON);
    assign ovf_clr  = mmio_wr && (d_off == OFF_STATUS) && dmem_wrdata[2];
    assign halt_set = mmio_wr && (d_off == OFF_HALT) && dmem_wrdata[0];

    // ------------------------------------------------------------------
    // Console FIFO: pointers carry one wrap bit above the index
    // ------------------------------------------------------------------
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        ovf;
    logic [31:0] cycle_cnt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign pop        = !fifo_empty && con_ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push       = push_req && (!fifo_full || pop);

    assign con_valid  = !fifo_empty;
    assign con_data   = fifo_mem[rd_ptr[PW-1:0]];

    // Byte-lane RAM write; no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (d_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wrstb[i]) begin
                    ram[d_idx][8*i +: 8] <= dmem_wrdata[8*i +: 8];
                end
            end
        end
    end

    // FIFO payload write; when full with a concurrent pop this overwrites the slot leaving at this edge
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= dmem_wrdata[7:0];
        end
    end

    // Control state: pointers, overflow flag, halt flag and free-running cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
            halt      <= 1'b0;
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // set and clear sit at different offsets, so they never collide
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (halt_set) begin
                halt <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read paths: purely combinational, so they show pre-edge state
    // ------------------------------------------------------------------

    // Fetch port sees RAM only; MMIO and unmapped fetches read as zero
    always_comb begin
        imem_data = 32'h0;
        if (i_ram) begin
            imem_data = ram[i_idx];
        end
    end

    // Load port: RAM, then MMIO registers, otherwise zero
    always_comb begin
        dmem_rddata = 32'h0;
        if (d_ram) begin
            dmem_rddata = ram[d_idx];
        end else if (d_mmio) begin
            case (d_off)
                OFF_CYCLE:  dmem_rddata = cycle_cnt;
                OFF_CON:    dmem_rddata = 32'h0;
                OFF_STATUS: dmem_rddata = {29'b0, ovf, fifo_full, fifo_empty};
                OFF_HALT:   dmem_rddata = {31'b0, halt};
                default:    dmem_rddata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mina_mem_sys.sv
module tb_mina_mem_sys;

    localparam logic [31:0] MB = 32'hF000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wrdata;
    logic [3:0]  dmem_wrstb;
    logic [31:0] dmem_rddata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        halt;

    mina_mem_sys dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wrdata(dmem_wrdata),
        .dmem_wrstb (dmem_wrstb),
        .dmem_rddata(dmem_rddata),
        .con_valid  (con_valid),
        .con_data   (con_data),
        .con_ready  (con_ready),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc_exp  = 32'd0;
    logic [7:0]  exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        bit          dchk;
        logic [31:0] dexp;
        logic [31:0] iaddr;
        bit          ichk;
        logic [31:0] iexp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock; the expected CYCLE value tracks the edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        cyc_exp = rst_n ? cyc_exp + 32'd1 : 32'd0;
        #1;
    endtask

    task automatic dmem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dmem_addr   = a;
        dmem_wrdata = d;
        dmem_wrstb  = s;
    endtask

    // Console scoreboard: at each negedge, a held byte must match the queue head; a pop consumes it
    always @(negedge clk) begin
        if (rst_n && con_valid) begin
            if (exp_q.size() == 0) begin
                check("con_unexpected_byte", {24'h0, con_data}, 32'hFFFF_FFFF);
            end else if (con_ready) begin
                check("con_pop_data", {24'h0, con_data}, {24'h0, exp_q.pop_front()});
            end else begin
                check("con_hold_data", {24'h0, con_data}, {24'h0, exp_q[0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        imem_addr = 32'h0;
        con_ready = 1'b0;
        dmem(32'h0, 32'h0, 4'h0);

        vecs.push_back('{32'h0000_0100, 32'h1122_3344, 4'hF, 0, 32'h0,         32'h0,         0, 32'h0});
        vecs.push_back('{32'h0000_0100, 32'hAABB_CCDD, 4'h5, 1, 32'h1122_3344, 32'h0000_0100, 1, 32'h1122_3344});
        vecs.push_back('{32'h0000_0100, 32'h0,         4'h0, 1, 32'h11BB_33DD, 32'h0000_0100, 1, 32'h11BB_33DD});
        vecs.push_back('{32'h0000_0040, 32'h0,         4'hF, 0, 32'h0,         32'h0,         0, 32'h0});
        vecs.push_back('{32'h0000_0040, 32'h5,         4'hF, 1, 32'h0,         32'h0000_0040, 1, 32'h0});
        vecs.push_back('{32'h0000_0040, 32'h0,         4'h0, 1, 32'h5,         32'h0000_0040, 1, 32'h5});
        vecs.push_back('{32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         32'h8000_0000, 1, 32'h0});
        vecs.push_back('{32'h8000_0000, 32'h0,         4'h0, 1, 32'h0,         MB,            1, 32'h0});
        vecs.push_back('{32'h0000_0103, 32'h0,         4'h0, 1, 32'h11BB_33DD, 32'h0000_0102, 1, 32'h11BB_33DD});
        vecs.push_back('{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         32'h0,         0, 32'h0});
        vecs.push_back('{32'h0000_FFFC, 32'h1234_5678, 4'hF, 0, 32'h0,         32'h0,         0, 32'h0});
        vecs.push_back('{32'h0001_0000, 32'h5555_AAAA, 4'hF, 1, 32'h0,         32'h0001_0000, 1, 32'h0});
        vecs.push_back('{32'h0000_0000, 32'h0,         4'h0, 1, 32'hCAFE_F00D, 32'h0000_FFFC, 1, 32'h1234_5678});
        vecs.push_back('{32'h0001_0000, 32'h0,         4'h0, 1, 32'h0,         32'h0000_0000, 1, 32'hCAFE_F00D});
        vecs.push_back('{MB + 32'h4,    32'h0,         4'h0, 1, 32'h0,         MB + 32'h8,    1, 32'h0});
        vecs.push_back('{MB + 32'h8,    32'h0,         4'h0, 1, 32'h1,         32'h0,         0, 32'h0});
        vecs.push_back('{MB + 32'hC,    32'h0,         4'h0, 1, 32'h0,         32'h0,         0, 32'h0});
        vecs.push_back('{MB + 32'h10,   32'h0,         4'h0, 1, 32'h0,         32'h0,         0, 32'h0});

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_con_valid", {31'b0, con_valid}, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        rst_n = 1'b1;
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("rst_status", dmem_rddata, 32'h1);
        dmem(MB, 32'h0, 4'h0);
        #1 check("rst_cycle", dmem_rddata, 32'h0);
        tick();

        // ---------------- RAM / decode vector table ----------------
        foreach (vecs[k]) begin
            dmem(vecs[k].addr, vecs[k].wdata, vecs[k].wstb);
            imem_addr = vecs[k].iaddr;
            #1;
            if (vecs[k].dchk) check($sformatf("vec%0d_dmem", k), dmem_rddata, vecs[k].dexp);
            if (vecs[k].ichk) check($sformatf("vec%0d_imem", k), imem_data, vecs[k].iexp);
            tick();
        end
        dmem(32'h0, 32'h0, 4'h0);
        imem_addr = 32'h0;

        // ---------------- CYCLE counter ----------------
        for (int i = 0; i < 3; i++) begin
            dmem(MB, 32'h0, 4'h0);
            #1 check("cycle_consecutive", dmem_rddata, cyc_exp);
            tick();
        end
        dmem(MB, 32'h1234_0000, 4'hF);
        tick();
        dmem(MB, 32'h0, 4'h0);
        #1 check("cycle_write_ignored", dmem_rddata, cyc_exp);
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        cyc_exp = 32'hFFFF_FFFE;
        #1 check("cycle_forced", dmem_rddata, 32'hFFFF_FFFE);
        release dut.cycle_cnt;
        tick();
        check("cycle_max", dmem_rddata, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", dmem_rddata, 32'h0);

        // ---------------- console basic ----------------
        con_ready = 1'b0;
        dmem(MB + 32'h4, 32'h48, 4'h1);
        exp_q.push_back(8'h48);
        #1 check("con_no_bypass", {31'b0, con_valid}, 32'h0);
        tick();
        dmem(MB + 32'h4, 32'h69, 4'h1);
        exp_q.push_back(8'h69);
        #1 check("con_valid_rise", {31'b0, con_valid}, 32'h1);
        check("con_data_first", {24'h0, con_data}, 32'h48);
        tick();
        dmem(32'h0, 32'h0, 4'h0);
        tick();
        tick();
        con_ready = 1'b1;
        tick();
        tick();
        con_ready = 1'b0;
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("con_drained_valid", {31'b0, con_valid}, 32'h0);
        check("con_drained_queue", exp_q.size(), 32'h0);
        check("con_status_empty", dmem_rddata, 32'h1);
        tick();

        // ---------------- overflow ----------------
        for (int i = 0; i < 9; i++) begin
            dmem(MB + 32'h4, 32'h30 + i, 4'h1);
            if (i < 8) exp_q.push_back(8'h30 + 8'(i));
            tick();
        end
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("ovf_status", dmem_rddata, 32'h6);
        check("ovf_head", {24'h0, con_data}, 32'h30);
        tick();
        con_ready = 1'b1;
        dmem(MB + 32'h4, 32'h50, 4'h1);
        exp_q.push_back(8'h50);
        tick();
        con_ready = 1'b0;
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("ovf_full_push_pop", dmem_rddata, 32'h6);
        tick();
        dmem(MB + 32'h8, 32'h4, 4'h1);
        #1 check("ovf_clear_pre_edge", dmem_rddata, 32'h6);
        tick();
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("ovf_cleared", dmem_rddata, 32'h2);
        con_ready = 1'b1;
        repeat (8) tick();
        con_ready = 1'b0;
        #1 check("ovf_drained_valid", {31'b0, con_valid}, 32'h0);
        check("ovf_drained_queue", exp_q.size(), 32'h0);
        check("ovf_status_final", dmem_rddata, 32'h1);
        tick();

        // ---------------- halt and mid-stream reset ----------------
        dmem(MB + 32'hC, 32'h1, 4'h1);
        #1 check("halt_pre_edge", {31'b0, halt}, 32'h0);
        tick();
        dmem(MB + 32'hC, 32'h0, 4'h1);
        #1 check("halt_set", {31'b0, halt}, 32'h1);
        check("halt_read", dmem_rddata, 32'h1);
        tick();
        dmem(MB + 32'hC, 32'h0, 4'h0);
        #1 check("halt_sticky", {31'b0, halt}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            dmem(MB + 32'h4, 32'h61 + i, 4'h1);
            exp_q.push_back(8'h61 + 8'(i));
            tick();
        end
        dmem(32'h0, 32'h0, 4'h0);
        #1 check("pre_reset_valid", {31'b0, con_valid}, 32'h1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        dmem(MB, 32'h0, 4'h0);
        #1 check("reset_con_valid", {31'b0, con_valid}, 32'h0);
        check("reset_halt", {31'b0, halt}, 32'h0);
        check("reset_cycle", dmem_rddata, cyc_exp);
        dmem(32'h0000_0100, 32'h0, 4'h0);
        #1 check("reset_ram_kept", dmem_rddata, 32'h11BB_33DD);
        dmem(MB + 32'h8, 32'h0, 4'h0);
        #1 check("reset_status", dmem_rddata, 32'h1);
        rst_n = 1'b1;
        tick();
        dmem(MB, 32'h0, 4'h0);
        #1 check("post_reset_cycle", dmem_rddata, 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
